// File: rtl/cpu_types_pkg.sv
// -----------------------------------------------------------------------------
// cpu_types_pkg
// Shared types for the 5-stage MIPS pipeline: datapath word, register index,
// writeback-select encodings and the EX/MEM access-tracking state.
// -----------------------------------------------------------------------------
package cpu_types_pkg;

  localparam int WORD_W = 32;
  localparam int REG_W  = 5;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [REG_W-1:0]  regbits_t;

  // Writeback source select carried down the pipe as MemtoReg.
  typedef enum logic [1:0] {
    MTR_ALU = 2'd0,
    MTR_MEM = 2'd1,
    MTR_LUI = 2'd2,
    MTR_PC4 = 2'd3
  } memtoreg_t;

  // IDLE: no access, REQ: access outstanding, DONE: access complete and
  // waiting for the pipeline to advance.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } ex_mem_state_t;

  function automatic logic is_mem_op(input logic dren, input logic dwen);
    return dren | dwen;
  endfunction

endpackage

// File: rtl/ex_mem_if.sv
// -----------------------------------------------------------------------------
// EX_MEM_if
// Signal bundle for the EX/MEM pipeline register. The ex_mem modport is the
// latch's view: execute-stage results and pipeline controls in, registered
// copies plus the outstanding-access flag out.
// -----------------------------------------------------------------------------
interface EX_MEM_if;
  import cpu_types_pkg::*;

  // pipeline control
  logic     ihit, dhit, stall, flush;
  // execute-stage results
  word_t    portO, dmemstore, LUI, pcp4;
  logic [1:0] MemtoReg;
  regbits_t Wsel;
  logic     RegWEN, dREN, dWEN, halt;
  // registered copies toward MEM / M_WB
  word_t    portO_out, dmemstore_out, LUI_out, pcp4_out;
  logic [1:0] MemtoReg_out;
  regbits_t Wsel_out;
  logic     RegWEN_out, dREN_out, dWEN_out, halt_out;
  logic     mem_busy;

  modport ex_mem (
    input  ihit, dhit, stall, flush,
    input  portO, dmemstore, LUI, pcp4, MemtoReg, Wsel,
    input  RegWEN, dREN, dWEN, halt,
    output portO_out, dmemstore_out, LUI_out, pcp4_out, MemtoReg_out, Wsel_out,
    output RegWEN_out, dREN_out, dWEN_out, halt_out, mem_busy
  );
endinterface

// File: rtl/ex_mem_latch.sv
// -----------------------------------------------------------------------------
// ex_mem_latch
// EX/MEM pipeline register. Captures execute results when the pipeline
// advances (ihit & ~stall), inserts a bubble on flush, and drops dREN/dWEN as
// soon as dhit returns so a finished load/store is not reissued while the
// pipeline waits on ihit. halt_out is sticky until RST.
//
// Ports:
//   CLK, RST                 clock, synchronous active-high reset
//   ihit, dhit, stall, flush pipeline controls
//   portO, dmemstore, LUI,   execute-stage data (WORD_W)
//   pcp4
//   MemtoReg, Wsel, RegWEN,  execute-stage control
//   dREN, dWEN, halt
//   *_out                    registered copies, 1-cycle latency
//   mem_busy                 data-memory request outstanding
// -----------------------------------------------------------------------------
module ex_mem_latch
  import cpu_types_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       ihit,
  input  logic       dhit,
  input  logic       stall,
  input  logic       flush,
  input  word_t      portO,
  input  word_t      dmemstore,
  input  word_t      LUI,
  input  word_t      pcp4,
  input  logic [1:0] MemtoReg,
  input  regbits_t   Wsel,
  input  logic       RegWEN,
  input  logic       dREN,
  input  logic       dWEN,
  input  logic       halt,
  output word_t      portO_out,
  output word_t      dmemstore_out,
  output word_t      LUI_out,
  output word_t      pcp4_out,
  output logic [1:0] MemtoReg_out,
  output regbits_t   Wsel_out,
  output logic       RegWEN_out,
  output logic       dREN_out,
  output logic       dWEN_out,
  output logic       halt_out,
  output logic       mem_busy
);

  EX_MEM_if exm ();

  assign exm.ihit      = ihit;
  assign exm.dhit      = dhit;
  assign exm.stall     = stall;
  assign exm.flush     = flush;
  assign exm.portO     = portO;
  assign exm.dmemstore = dmemstore;
  assign exm.LUI       = LUI;
  assign exm.pcp4      = pcp4;
  assign exm.MemtoReg  = MemtoReg;
  assign exm.Wsel      = Wsel;
  assign exm.RegWEN    = RegWEN;
  assign exm.dREN      = dREN;
  assign exm.dWEN      = dWEN;
  assign exm.halt      = halt;

  ex_mem_state_t r_state;
  ex_mem_state_t w_next_state;
  logic          w_advance;
  logic          w_dhit_drop;

  word_t      r_portO, r_dmemstore, r_LUI, r_pcp4;
  logic [1:0] r_MemtoReg;
  regbits_t   r_Wsel;
  logic       r_RegWEN, r_dREN, r_dWEN, r_halt;

  assign w_advance = exm.ihit & ~exm.stall;

  // Priority: flush > advance > dhit-drop > hold. On a same-edge dhit and
  // advance the new instruction's request wins and the old one is complete.
  // NOTE: every output of an always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    w_dhit_drop  = 1'b0;
    if (exm.flush) begin
      w_next_state = IDLE;
    end else if (w_advance) begin
      w_next_state = is_mem_op(exm.dREN, exm.dWEN) ? REQ : IDLE;
    end else if (exm.dhit && r_state == REQ) begin
      w_next_state = DONE;
      w_dhit_drop  = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= IDLE;
      r_portO     <= '0;
      r_dmemstore <= '0;
      r_LUI       <= '0;
      r_pcp4      <= '0;
      r_MemtoReg  <= '0;
      r_Wsel      <= '0;
      r_RegWEN    <= 1'b0;
      r_dREN      <= 1'b0;
      r_dWEN      <= 1'b0;
      r_halt      <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (exm.flush) begin
        // Bubble: halt_out deliberately survives a flush.
        r_portO     <= '0;
        r_dmemstore <= '0;
        r_LUI       <= '0;
        r_pcp4      <= '0;
        r_MemtoReg  <= '0;
        r_Wsel      <= '0;
        r_RegWEN    <= 1'b0;
        r_dREN      <= 1'b0;
        r_dWEN      <= 1'b0;
      end else if (w_advance) begin
        r_portO     <= exm.portO;
        r_dmemstore <= exm.dmemstore;
        r_LUI       <= exm.LUI;
        r_pcp4      <= exm.pcp4;
        r_MemtoReg  <= exm.MemtoReg;
        r_Wsel      <= exm.Wsel;
        r_RegWEN    <= exm.RegWEN;
        r_dREN      <= exm.dREN;
        r_dWEN      <= exm.dWEN;
        r_halt      <= r_halt | exm.halt;
      end else if (w_dhit_drop) begin
        // Access finished: stop requesting, keep writeback info for M_WB.
        r_dREN <= 1'b0;
        r_dWEN <= 1'b0;
      end
    end
  end

  assign exm.portO_out     = r_portO;
  assign exm.dmemstore_out = r_dmemstore;
  assign exm.LUI_out       = r_LUI;
  assign exm.pcp4_out      = r_pcp4;
  assign exm.MemtoReg_out  = r_MemtoReg;
  assign exm.Wsel_out      = r_Wsel;
  assign exm.RegWEN_out    = r_RegWEN;
  assign exm.dREN_out      = r_dREN;
  assign exm.dWEN_out      = r_dWEN;
  assign exm.halt_out      = r_halt;
  assign exm.mem_busy      = (r_dREN | r_dWEN) & (r_state == REQ);

  assign portO_out     = exm.portO_out;
  assign dmemstore_out = exm.dmemstore_out;
  assign LUI_out       = exm.LUI_out;
  assign pcp4_out      = exm.pcp4_out;
  assign MemtoReg_out  = exm.MemtoReg_out;
  assign Wsel_out      = exm.Wsel_out;
  assign RegWEN_out    = exm.RegWEN_out;
  assign dREN_out      = exm.dREN_out;
  assign dWEN_out      = exm.dWEN_out;
  assign halt_out      = exm.halt_out;
  assign mem_busy      = exm.mem_busy;

endmodule

// File: tb/tb_ex_mem_latch.sv
// -----------------------------------------------------------------------------
// tb_ex_mem_latch
// Scoreboard bench: each driven cycle pushes the reference model's expected
// outputs; a monitor pops one entry after every rising edge and compares.
// -----------------------------------------------------------------------------
module tb_ex_mem_latch;
  import cpu_types_pkg::*;

  typedef struct {
    logic       rst, ihit, dhit, stall, flush;
    word_t      portO, dmemstore, lui, pcp4;
    logic [1:0] m2r;
    regbits_t   wsel;
    logic       regwen, dren, dwen, halt;
  } in_t;

  typedef struct {
    word_t      portO, dmemstore, lui, pcp4;
    logic [1:0] m2r;
    regbits_t   wsel;
    logic       regwen, dren, dwen, halt, busy;
  } out_t;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       ihit = 1'b0, dhit = 1'b0, stall = 1'b0, flush = 1'b0;
  word_t      portO = '0, dmemstore = '0, LUI = '0, pcp4 = '0;
  logic [1:0] MemtoReg = '0;
  regbits_t   Wsel = '0;
  logic       RegWEN = 1'b0, dREN = 1'b0, dWEN = 1'b0, halt = 1'b0;
  word_t      portO_out, dmemstore_out, LUI_out, pcp4_out;
  logic [1:0] MemtoReg_out;
  regbits_t   Wsel_out;
  logic       RegWEN_out, dREN_out, dWEN_out, halt_out, mem_busy;

  ex_mem_latch dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .stall(stall), .flush(flush),
    .portO(portO), .dmemstore(dmemstore), .LUI(LUI), .pcp4(pcp4),
    .MemtoReg(MemtoReg), .Wsel(Wsel), .RegWEN(RegWEN), .dREN(dREN), .dWEN(dWEN),
    .halt(halt),
    .portO_out(portO_out), .dmemstore_out(dmemstore_out), .LUI_out(LUI_out),
    .pcp4_out(pcp4_out), .MemtoReg_out(MemtoReg_out), .Wsel_out(Wsel_out),
    .RegWEN_out(RegWEN_out), .dREN_out(dREN_out), .dWEN_out(dWEN_out),
    .halt_out(halt_out), .mem_busy(mem_busy)
  );

  always #5 CLK = ~CLK;

  out_t   exp_q[$];
  string  tag_q[$];
  int     checks = 0;
  int     errors = 0;

  // Reference model: the pipeline register contents plus one flag saying
  // whether a data access launched by the held instruction is still pending.
  out_t m;
  bit   pending = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic in_t idle_in();
    in_t t;
    t = '{rst: 1'b0, ihit: 1'b0, dhit: 1'b0, stall: 1'b0, flush: 1'b0,
          portO: '0, dmemstore: '0, lui: '0, pcp4: '0, m2r: '0, wsel: '0,
          regwen: 1'b0, dren: 1'b0, dwen: 1'b0, halt: 1'b0};
    return t;
  endfunction

  task automatic model_apply(input in_t t);
    if (t.rst) begin
      m = '{portO: '0, dmemstore: '0, lui: '0, pcp4: '0, m2r: '0, wsel: '0,
            regwen: 1'b0, dren: 1'b0, dwen: 1'b0, halt: 1'b0, busy: 1'b0};
      pending = 1'b0;
    end else if (t.flush) begin
      m.portO = '0; m.dmemstore = '0; m.lui = '0; m.pcp4 = '0;
      m.m2r = '0; m.wsel = '0; m.regwen = 1'b0; m.dren = 1'b0; m.dwen = 1'b0;
      pending = 1'b0;
    end else if (t.ihit && !t.stall) begin
      m.portO = t.portO; m.dmemstore = t.dmemstore; m.lui = t.lui; m.pcp4 = t.pcp4;
      m.m2r = t.m2r; m.wsel = t.wsel; m.regwen = t.regwen;
      m.dren = t.dren; m.dwen = t.dwen;
      m.halt = m.halt || t.halt;
      pending = t.dren || t.dwen;
    end else if (t.dhit && pending) begin
      m.dren = 1'b0; m.dwen = 1'b0;
      pending = 1'b0;
    end
    m.busy = pending && (m.dren || m.dwen);
  endtask

  // Drive one cycle of inputs on the falling edge and queue the expectation
  // for the following rising edge.
  task automatic step(input in_t t, input string tag);
    @(negedge CLK);
    RST = t.rst; ihit = t.ihit; dhit = t.dhit; stall = t.stall; flush = t.flush;
    portO = t.portO; dmemstore = t.dmemstore; LUI = t.lui; pcp4 = t.pcp4;
    MemtoReg = t.m2r; Wsel = t.wsel; RegWEN = t.regwen;
    dREN = t.dren; dWEN = t.dwen; halt = t.halt;
    model_apply(t);
    exp_q.push_back(m);
    tag_q.push_back(tag);
  endtask

  // Monitor: one expectation per rising edge, sampled 1 time unit later.
  initial begin
    out_t  e;
    string tg;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        tg = tag_q.pop_front();
        check({tg, ".portO_out"},     portO_out,            e.portO);
        check({tg, ".dmemstore_out"}, dmemstore_out,        e.dmemstore);
        check({tg, ".LUI_out"},       LUI_out,              e.lui);
        check({tg, ".pcp4_out"},      pcp4_out,             e.pcp4);
        check({tg, ".MemtoReg_out"},  {30'd0, MemtoReg_out}, {30'd0, e.m2r});
        check({tg, ".Wsel_out"},      {27'd0, Wsel_out},    {27'd0, e.wsel});
        check({tg, ".RegWEN_out"},    {31'd0, RegWEN_out},  {31'd0, e.regwen});
        check({tg, ".dREN_out"},      {31'd0, dREN_out},    {31'd0, e.dren});
        check({tg, ".dWEN_out"},      {31'd0, dWEN_out},    {31'd0, e.dwen});
        check({tg, ".halt_out"},      {31'd0, halt_out},    {31'd0, e.halt});
        check({tg, ".mem_busy"},      {31'd0, mem_busy},    {31'd0, e.busy});
      end
    end
  end

  initial begin
    in_t t;
    int  r;

    // Reset, then reset in the middle of an outstanding load.
    t = idle_in(); t.rst = 1'b1; step(t, "reset");
    t = idle_in(); t.ihit = 1'b1; t.dren = 1'b1; t.portO = 32'h200; t.wsel = 5'd3;
    t.regwen = 1'b1; t.m2r = 2'd1; step(t, "load_for_reset");
    t = idle_in(); t.rst = 1'b1; step(t, "reset_mid_access");

    // ALU op advance.
    t = idle_in(); t.ihit = 1'b1; t.portO = 32'h0000_00F0; t.wsel = 5'd5; t.regwen = 1'b1;
    step(t, "alu_advance");

    // Load with early dhit, then hold, then the next instruction.
    t = idle_in(); t.ihit = 1'b1; t.dren = 1'b1; t.portO = 32'h100; t.wsel = 5'd7;
    t.regwen = 1'b1; t.m2r = 2'd1; step(t, "load_capture");
    t = idle_in(); t.dhit = 1'b1; step(t, "load_dhit");
    t = idle_in(); step(t, "load_done_hold");
    t = idle_in(); t.dhit = 1'b1; step(t, "dhit_in_done_ignored");
    t = idle_in(); t.ihit = 1'b1; t.portO = 32'h44; t.wsel = 5'd2; t.regwen = 1'b1;
    step(t, "after_load");

    // Same-edge dhit and advance: store outstanding, load arrives.
    t = idle_in(); t.ihit = 1'b1; t.dwen = 1'b1; t.portO = 32'h300; t.dmemstore = 32'hDEAD_BEEF;
    step(t, "store_capture");
    t = idle_in(); t.ihit = 1'b1; t.dhit = 1'b1; t.dren = 1'b1; t.wsel = 5'd9;
    t.regwen = 1'b1; t.portO = 32'h304; step(t, "dhit_and_advance");

    // Stall holds; flush beats ihit.
    t = idle_in(); t.ihit = 1'b1; t.stall = 1'b1; t.portO = 32'h999; t.wsel = 5'd31;
    step(t, "stall_hold");
    t = idle_in(); t.ihit = 1'b1; t.flush = 1'b1; t.regwen = 1'b1; t.portO = 32'h555;
    step(t, "flush");

    // Sticky halt through flush and a halt=0 capture, cleared only by reset.
    t = idle_in(); t.ihit = 1'b1; t.halt = 1'b1; step(t, "halt_set");
    t = idle_in(); t.flush = 1'b1; step(t, "halt_after_flush");
    t = idle_in(); t.ihit = 1'b1; t.portO = 32'h12; step(t, "halt_sticky");
    t = idle_in(); t.rst = 1'b1; step(t, "halt_reset");

    // Randomized traffic, including both dREN and dWEN set together.
    for (int i = 0; i < 400; i++) begin
      t = idle_in();
      r = int'($urandom_range(0, 99));
      t.rst   = (r < 2);
      t.flush = ($urandom_range(0, 9) == 0);
      t.ihit  = ($urandom_range(0, 1) == 1);
      t.stall = ($urandom_range(0, 3) == 0);
      t.dhit  = ($urandom_range(0, 2) == 0);
      t.portO = $urandom; t.dmemstore = $urandom; t.lui = $urandom; t.pcp4 = $urandom;
      t.m2r   = 2'($urandom_range(0, 3));
      t.wsel  = 5'($urandom_range(0, 31));
      t.regwen = 1'($urandom_range(0, 1));
      r = int'($urandom_range(0, 7));
      t.dren = (r == 1) || (r == 2) || (r == 7);
      t.dwen = (r == 3) || (r == 4) || (r == 7);
      t.halt = ($urandom_range(0, 29) == 0);
      step(t, "random");
    end

    t = idle_in(); step(t, "final_idle");
    repeat (3) @(posedge CLK);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
